// File: rtl/dac_cfg_pkg.sv
// Shared widths, field codes and the per-DAC configuration record for the
// DAC configuration scheduler.
package dac_cfg_pkg;

    localparam int STREAM_W = 4;
    localparam int CHAN_W   = 6;
    localparam int GAIN_W   = 3;
    localparam int NS_W     = 7;

    localparam logic [2:0] FIELD_SOURCE = 3'd0;
    localparam logic [2:0] FIELD_EN     = 3'd1;
    localparam logic [2:0] FIELD_THRSH  = 3'd2;
    localparam logic [2:0] FIELD_POL    = 3'd3;
    localparam logic [2:0] FIELD_GAIN   = 3'd4;
    localparam logic [2:0] FIELD_NOISE  = 3'd5;

    localparam logic [15:0] DAC_MIDSCALE = 16'h8000;

    typedef struct packed {
        logic [STREAM_W-1:0] src_stream;
        logic [CHAN_W-1:0]   src_chan;
        logic                en;
        logic [15:0]         thrsh;
        logic                pol;
    } dac_cfg_t;

    // Global fields ignore cfg_addr, so they are never rejected for a bad index.
    function automatic logic field_is_global(input logic [2:0] field);
        return (field == FIELD_GAIN) || (field == FIELD_NOISE);
    endfunction

endpackage

// File: rtl/dac_capture_slot.sv
// One DAC's sample latch: captures matching amplifier samples and returns to
// midscale when the commit edge changes this DAC's source.
module dac_capture_slot
    import dac_cfg_pkg::*;
(
    input  logic                dataclk,
    input  logic                reset_n,
    input  logic                smp_valid,
    input  logic [STREAM_W-1:0] smp_stream,
    input  logic [CHAN_W-1:0]   smp_channel,
    input  logic [15:0]         smp_data,
    input  logic [STREAM_W-1:0] src_stream,
    input  logic [CHAN_W-1:0]   src_chan,
    input  logic                src_change,
    output logic [15:0]         dac_input
);

    logic [15:0] sample_q;
    logic [15:0] sample_d;
    logic        match;

    assign match = smp_valid && (smp_stream == src_stream) && (smp_channel == src_chan);

    // A source change wins over a coincident sample matching the outgoing source.
    always_comb begin
        sample_d = sample_q;
        if (src_change) begin
            sample_d = DAC_MIDSCALE;
        end else if (match) begin
            sample_d = smp_data;
        end
    end

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= DAC_MIDSCALE;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign dac_input = sample_q;

endmodule

// File: rtl/dac_config_scheduler.sv
// Shadow/active configuration banks for the DAC outputs with frame-boundary
// atomic commit, plus per-DAC sample routing.
module dac_config_scheduler
    import dac_cfg_pkg::*;
#(
    parameter int NUM_DACS = 8,
    parameter int ms_wait  = 99
) (
    input  logic                   dataclk,
    input  logic                   reset_n,
    input  logic [31:0]            main_state,
    input  logic                   cfg_wr_en,
    input  logic [2:0]             cfg_addr,
    input  logic [2:0]             cfg_field,
    input  logic [15:0]            cfg_data,
    output logic                   cfg_pending,
    output logic                   cfg_err,
    output logic                   commit_pulse,
    input  logic                   smp_valid,
    input  logic [STREAM_W-1:0]    smp_stream,
    input  logic [CHAN_W-1:0]      smp_channel,
    input  logic [15:0]            smp_data,
    output logic [16*NUM_DACS-1:0] dac_input_bus,
    output logic [NUM_DACS-1:0]    dac_en_bus,
    output logic [16*NUM_DACS-1:0] dac_thrsh_bus,
    output logic [NUM_DACS-1:0]    dac_thrsh_pol_bus,
    output logic [GAIN_W-1:0]      gain,
    output logic [NS_W-1:0]        noise_suppress
);

    logic              field_known;
    logic              addr_ok;
    logic              wr_ok;
    logic              commit;
    logic              pending_q;
    logic              pending_d;
    logic              err_q;
    logic              commit_pulse_q;
    logic [GAIN_W-1:0] gain_shadow_q;
    logic [GAIN_W-1:0] gain_shadow_d;
    logic [GAIN_W-1:0] gain_active_q;
    logic [NS_W-1:0]   ns_shadow_q;
    logic [NS_W-1:0]   ns_shadow_d;
    logic [NS_W-1:0]   ns_active_q;

    assign field_known = (cfg_field <= FIELD_NOISE);
    assign addr_ok     = (int'(cfg_addr) < NUM_DACS);
    assign wr_ok       = cfg_wr_en && field_known && (field_is_global(cfg_field) || addr_ok);
    assign commit      = (main_state == 32'(ms_wait)) && pending_q;

    // A write coinciding with a commit must survive it, so it re-arms pending.
    always_comb begin
        pending_d = pending_q;
        if (wr_ok) begin
            pending_d = 1'b1;
        end else if (commit) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        gain_shadow_d = gain_shadow_q;
        ns_shadow_d   = ns_shadow_q;
        if (wr_ok && cfg_field == FIELD_GAIN) begin
            gain_shadow_d = cfg_data[GAIN_W-1:0];
        end
        if (wr_ok && cfg_field == FIELD_NOISE) begin
            ns_shadow_d = cfg_data[NS_W-1:0];
        end
    end

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q      <= 1'b0;
            err_q          <= 1'b0;
            commit_pulse_q <= 1'b0;
            gain_shadow_q  <= '0;
            gain_active_q  <= '0;
            ns_shadow_q    <= '0;
            ns_active_q    <= '0;
        end else begin
            pending_q      <= pending_d;
            err_q          <= cfg_wr_en && !wr_ok;
            commit_pulse_q <= commit;
            gain_shadow_q  <= gain_shadow_d;
            ns_shadow_q    <= ns_shadow_d;
            if (commit) begin
                gain_active_q <= gain_shadow_q;
                ns_active_q   <= ns_shadow_q;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DACS; gi++) begin : g_dac
            dac_cfg_t shadow_q;
            dac_cfg_t shadow_d;
            dac_cfg_t active_q;
            logic     wr_hit;
            logic     src_change;

            assign wr_hit = wr_ok && !field_is_global(cfg_field) && (int'(cfg_addr) == gi);

            always_comb begin
                shadow_d = shadow_q;
                if (wr_hit) begin
                    case (cfg_field)
                        FIELD_SOURCE: begin
                            shadow_d.src_stream = cfg_data[CHAN_W+STREAM_W-1:CHAN_W];
                            shadow_d.src_chan   = cfg_data[CHAN_W-1:0];
                        end
                        FIELD_EN:    shadow_d.en    = cfg_data[0];
                        FIELD_THRSH: shadow_d.thrsh = cfg_data;
                        FIELD_POL:   shadow_d.pol   = cfg_data[0];
                        default:     shadow_d = shadow_q;
                    endcase
                end
            end

            // Commit copies the pre-write shadow; the write itself lands in shadow.
            always_ff @(posedge dataclk or negedge reset_n) begin
                if (!reset_n) begin
                    shadow_q <= '0;
                    active_q <= '0;
                end else begin
                    shadow_q <= shadow_d;
                    if (commit) begin
                        active_q <= shadow_q;
                    end
                end
            end

            assign src_change = commit &&
                ({shadow_q.src_stream, shadow_q.src_chan} != {active_q.src_stream, active_q.src_chan});

            dac_capture_slot u_slot (
                .dataclk     (dataclk),
                .reset_n     (reset_n),
                .smp_valid   (smp_valid),
                .smp_stream  (smp_stream),
                .smp_channel (smp_channel),
                .smp_data    (smp_data),
                .src_stream  (active_q.src_stream),
                .src_chan    (active_q.src_chan),
                .src_change  (src_change),
                .dac_input   (dac_input_bus[16*gi +: 16])
            );

            assign dac_en_bus[gi]             = active_q.en;
            assign dac_thrsh_bus[16*gi +: 16] = active_q.thrsh;
            assign dac_thrsh_pol_bus[gi]      = active_q.pol;
        end
    endgenerate

    assign cfg_pending    = pending_q;
    assign cfg_err        = err_q;
    assign commit_pulse   = commit_pulse_q;
    assign gain           = gain_active_q;
    assign noise_suppress = ns_active_q;

endmodule
